// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit:
// state encoding, instruction classes, opcode constants and the
// datapath mux / ALU-control encodings driven by the FSM.
package mc_ctrl_pkg;

    // Debug-visible 4-bit state codes; FETCH must be 0 and TRAP all-ones.
    typedef enum logic [3:0] {
        StFetch   = 4'h0,
        StDecode  = 4'h1,
        StMemAddr = 4'h2,
        StMemRd   = 4'h3,
        StMemWb   = 4'h4,
        StMemWr   = 4'h5,
        StRExec   = 4'h6,
        StRWb     = 4'h7,
        StIExec   = 4'h8,
        StIWb     = 4'h9,
        StBranch  = 4'hA,
        StJump    = 4'hB,
        StTrap    = 4'hF
    } state_e;

    typedef enum logic [2:0] {
        ClsMem,
        ClsR,
        ClsImm,
        ClsBranch,
        ClsJump,
        ClsIllegal
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b011;
    localparam logic [2:0] ALU_ANDI  = 3'b100;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode   in   IR[31:26]
//   iclass   out  instruction class (mem, R, imm, branch, jump, illegal)
//   is_lw    out  1 = lw (else sw) within the mem class
//   is_beq   out  1 = beq (else bne) within the branch class
//   is_andi  out  1 = andi (else addi) within the imm class
module opcode_class_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_e        iclass,
    output logic                is_lw,
    output logic                is_beq,
    output logic                is_andi
);

    logic [5:0] op6;
    assign op6 = 6'(opcode);

    assign is_lw   = (op6 == OP_LW);
    assign is_beq  = (op6 == OP_BEQ);
    assign is_andi = (op6 == OP_ANDI);

    always_comb begin
        iclass = ClsIllegal;
        case (op6)
            OP_LW, OP_SW:     iclass = ClsMem;
            OP_RTYPE:         iclass = ClsR;
            OP_ADDI, OP_ANDI: iclass = ClsImm;
            OP_BEQ, OP_BNE:   iclass = ClsBranch;
            OP_J:             iclass = ClsJump;
            default:          iclass = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control unit (Moore FSM) with memory wait
// handshake, wait timeout, sticky trap and per-instruction done pulse.
// Ports:
//   clk, reset (async, active-high)
//   opcode, mem_ready                    inputs
//   pc_write, pc_write_eq, pc_write_ne   PC write enables
//   iord, mem_read, mem_write, ir_write  memory address select / strobes / IR load
//   reg_dst, mem_to_reg, reg_write       register-file controls
//   alu_src_a, alu_src_b, alu_op         ALU operand / operation selects
//   pc_source                            PC mux select
//   instr_done, trap, state              status and debug
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_eq,
    output logic                pc_write_ne,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                trap,
    output logic [3:0]          state
);

    // Keep at least one bit so MAX_WAIT = 0 (timeout disabled) still elaborates.
    localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    instr_class_e iclass;
    logic         is_lw, is_beq, is_andi;
    logic         wait_expired;

    logic       pcw_c, pweq_c, pwne_c, iord_c, mrd_c, mwr_c, irw_c;
    logic       rdst_c, m2r_c, rw_c, srca_c, done_c, trap_c;
    logic [1:0] srcb_c, psrc_c;
    logic [2:0] aop_c;

    opcode_class_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode  (opcode),
        .iclass  (iclass),
        .is_lw   (is_lw),
        .is_beq  (is_beq),
        .is_andi (is_andi)
    );

    assign wait_expired = (MAX_WAIT != 0) && (cnt_q == CntW'(MAX_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // Counter only survives a cycle spent waiting in a memory state, which
        // also clears it on every entry to FETCH, MEM_RD or MEM_WR.
        cnt_d   = '0;
        pcw_c   = 1'b0;
        pweq_c  = 1'b0;
        pwne_c  = 1'b0;
        iord_c  = 1'b0;
        mrd_c   = 1'b0;
        mwr_c   = 1'b0;
        irw_c   = 1'b0;
        rdst_c  = 1'b0;
        m2r_c   = 1'b0;
        rw_c    = 1'b0;
        srca_c  = 1'b0;
        done_c  = 1'b0;
        trap_c  = 1'b0;
        srcb_c  = SRCB_REG;
        psrc_c  = PCSRC_ALU;
        aop_c   = ALU_ADD;

        unique case (state_q)
            StFetch: begin
                mrd_c  = 1'b1;
                srcb_c = SRCB_FOUR;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecode: begin
                srcb_c = SRCB_IMM_SH2;
                unique case (iclass)
                    ClsMem:    state_d = StMemAddr;
                    ClsR:      state_d = StRExec;
                    ClsImm:    state_d = StIExec;
                    ClsBranch: state_d = StBranch;
                    ClsJump:   state_d = StJump;
                    default:   state_d = StTrap;
                endcase
            end
            StMemAddr: begin
                srca_c  = 1'b1;
                srcb_c  = SRCB_IMM;
                state_d = is_lw ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord_c = 1'b1;
                mrd_c  = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (wait_expired) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMemWb: begin
                m2r_c   = 1'b1;
                rw_c    = 1'b1;
                done_c  = 1'b1;
                state_d = StFetch;
            end
            StMemWr: begin
                iord_c = 1'b1;
                mwr_c  = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = StFetch;
                end else if (wait_expired) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRExec: begin
                srca_c  = 1'b1;
                aop_c   = ALU_FUNCT;
                state_d = StRWb;
            end
            StRWb: begin
                rdst_c  = 1'b1;
                rw_c    = 1'b1;
                done_c  = 1'b1;
                state_d = StFetch;
            end
            StIExec: begin
                srca_c  = 1'b1;
                srcb_c  = SRCB_IMM;
                aop_c   = is_andi ? ALU_ANDI : ALU_ADDI;
                state_d = StIWb;
            end
            StIWb: begin
                rw_c    = 1'b1;
                done_c  = 1'b1;
                state_d = StFetch;
            end
            StBranch: begin
                srca_c  = 1'b1;
                aop_c   = ALU_SUB;
                psrc_c  = PCSRC_ALUOUT;
                done_c  = 1'b1;
                pweq_c  = is_beq;
                pwne_c  = ~is_beq;
                state_d = StFetch;
            end
            StJump: begin
                psrc_c  = PCSRC_JUMP;
                pcw_c   = 1'b1;
                done_c  = 1'b1;
                state_d = StFetch;
            end
            StTrap: begin
                trap_c = 1'b1;
            end
            default: begin
                // Unused codes fall into the trap rather than wander.
                state_d = StTrap;
            end
        endcase
    end

    // Reset gates every output combinationally so strobes drop the moment
    // reset rises, without waiting for a clock edge.
    assign pc_write    = pcw_c  & ~reset;
    assign pc_write_eq = pweq_c & ~reset;
    assign pc_write_ne = pwne_c & ~reset;
    assign iord        = iord_c & ~reset;
    assign mem_read    = mrd_c  & ~reset;
    assign mem_write   = mwr_c  & ~reset;
    assign ir_write    = irw_c  & ~reset;
    assign reg_dst     = rdst_c & ~reset;
    assign mem_to_reg  = m2r_c  & ~reset;
    assign reg_write   = rw_c   & ~reset;
    assign alu_src_a   = srca_c & ~reset;
    assign instr_done  = done_c & ~reset;
    assign trap        = trap_c & ~reset;
    assign alu_src_b   = reset ? 2'b00 : srcb_c;
    assign pc_source   = reset ? 2'b00 : psrc_c;
    assign alu_op      = reset ? '0 : ALUOP_W'(aop_c);
    assign state       = reset ? 4'h0 : state_q;

endmodule
